// File: rtl/sa_ctrl_param.sv
// N x N systolic-array input controller: issues A/B operand addresses, steers returned
// words into row/column FIFOs, then staggers the FIFO read enables on and off diagonally.

module sa_ctrl_lane #(
  parameter int LANE = 0,
  parameter int CW   = 3
) (
  input  logic          i_ramp_on,
  input  logic          i_ramp_off,
  input  logic          i_stream,
  input  logic [CW-1:0] i_k,
  input  logic          i_tok_v,
  input  logic [CW-1:0] i_tok_ch,
  output logic          o_ren,
  output logic          o_wen
);
  localparam logic [CW-1:0] ID = CW'(LANE);

  assign o_ren = i_stream | (i_ramp_on & (ID <= i_k)) | (i_ramp_off & (ID > i_k));
  assign o_wen = i_tok_v & (i_tok_ch == ID);
endmodule

module sa_ctrl_param #(
  parameter int N      = 8,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr_mtxA,
  input  logic [AW-1:0] addr_mtxB,
  input  logic [N-1:0]  fullR,
  input  logic [N-1:0]  fullC,
  input  logic [N-1:0]  emptyR,
  input  logic [N-1:0]  emptyC,
  output logic [AW-1:0] ad1,
  output logic [AW-1:0] ad2,
  output logic [N-1:0]  wen_row,
  output logic [N-1:0]  wen_col,
  output logic [N-1:0]  ren_row,
  output logic [N-1:0]  ren_col,
  output logic          busy,
  output logic          done,
  output logic          ovf
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] KL = CW'(N-1);
  localparam logic [CW-1:0] KO = CW'(N-2);
  localparam logic [1:0]    DL = 2'((RD_LAT > 0) ? RD_LAT-1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_RAMP_ON, S_STREAM, S_RAMP_OFF, S_DONE
  } state_t;

  state_t          r_state, w_nxt;
  logic [AW-1:0]   r_baseA, r_baseB, r_ad1, r_ad2;
  logic [CW-1:0]   r_ch, r_idx, r_k;
  logic [1:0]      r_dcnt;
  logic            r_vld_pipe [RD_LAT:0];
  logic [CW-1:0]   r_ch_pipe  [RD_LAT:0];
  logic [N-1:0]    r_ren;
  logic            r_busy, r_done, r_ovf;

  logic [N-1:0]    w_ren, w_wen;
  logic [AW-1:0]   w_off;
  logic            w_accept, w_stall, w_issue, w_last;
  logic            w_ramp_on, w_ramp_off, w_stream;

  assign w_accept   = (r_state == S_IDLE) & start;
  assign w_stall    = fullR[r_ch] | fullC[r_ch];
  assign w_issue    = (r_state == S_LOAD) & ~w_stall;
  assign w_last     = w_issue & (r_ch == KL) & (r_idx == KL);
  assign w_off      = AW'(r_ch) * AW'(N) + AW'(r_idx);
  assign w_ramp_on  = (r_state == S_RAMP_ON);
  assign w_ramp_off = (r_state == S_RAMP_OFF);
  assign w_stream   = (r_state == S_STREAM);

  // Lanes decode the write token and the diagonal read-enable ramp per channel.
  for (genvar g = 0; g < N; g++) begin : g_lane
    sa_ctrl_lane #(.LANE(g), .CW(CW)) u_lane (
      .i_ramp_on (w_ramp_on),
      .i_ramp_off(w_ramp_off),
      .i_stream  (w_stream),
      .i_k       (r_k),
      .i_tok_v   (r_vld_pipe[RD_LAT]),
      .i_tok_ch  (r_ch_pipe[RD_LAT]),
      .o_ren     (w_ren[g]),
      .o_wen     (w_wen[g])
    );
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_nxt = S_LOAD;
      S_LOAD:     if (w_last) w_nxt = (RD_LAT > 0) ? S_DRAIN : S_RAMP_ON;
      S_DRAIN:    if (r_dcnt == DL) w_nxt = S_RAMP_ON;
      S_RAMP_ON:  if (r_k == KL) w_nxt = S_STREAM;
      S_STREAM:   if (emptyR[0] | emptyC[0]) w_nxt = S_RAMP_OFF;
      S_RAMP_OFF: if (r_k == KO) w_nxt = S_DONE;
      S_DONE:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baseA <= '0;
      r_baseB <= '0;
      r_ad1   <= '0;
      r_ad2   <= '0;
      r_ch    <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
      r_ren   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) begin
        r_vld_pipe[i] <= 1'b0;
        r_ch_pipe[i]  <= '0;
      end
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_baseA <= addr_mtxA;
        r_baseB <= addr_mtxB;
        r_ch    <= '0;
        r_idx   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (|(w_wen & (fullR | fullC))) r_ovf <= 1'b1;
        if (w_issue) begin
          r_ad1 <= r_baseA + w_off;
          r_ad2 <= r_baseB + w_off;
          if (r_idx == KL) begin
            r_idx <= '0;
            r_ch  <= (r_ch == KL) ? '0 : r_ch + 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
      // Token stage 0 lines up with the registered address; the last stage with returned data.
      r_vld_pipe[0] <= w_issue;
      r_ch_pipe[0]  <= r_ch;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_ch_pipe[i]  <= r_ch_pipe[i-1];
      end
      if (r_state != w_nxt) r_k <= '0;
      else if (w_ramp_on | w_ramp_off) r_k <= r_k + 1'b1;
      if (r_state != w_nxt) r_dcnt <= '0;
      else if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 1'b1;
      // Status and read enables are presented one cycle after the state, like the addresses.
      r_ren  <= w_ren;
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);
    end
  end

  assign ad1     = r_ad1;
  assign ad2     = r_ad2;
  assign wen_row = w_wen;
  assign wen_col = w_wen;
  assign ren_row = r_ren;
  assign ren_col = r_ren;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
endmodule
